uart_rx: RTL
============

# uart_rx

Serial receiver stage for the UART. Takes the asynchronous `rx_bit` line and generates its own 16x oversampling tick from `freq_div`. Deframes 8N1 characters (LSB first) using majority-voted mid-bit sampling and pushes each good byte into the RX FIFO with a one-cycle push strobe. The Wishbone side reads bytes from that FIFO; this block never talks to Wishbone directly.

## Interface
Parameters:
- `SYNC_STAGES`, 2: flops in the `rx_bit` synchronizer; must be ≥2.

Ports:
- `clk` in 1: system clock, the same clock as the RX FIFO.
- `reset` in 1: synchronous, active-high; one clock, synchronous active-high reset.
- `rx_bit` in 1: serial line, asynchronous, idles high.
- `freq_div` in 8: tick period is `freq_div`+1 clk cycles; 16 ticks per bit.
- `fifo_full` in 1: RX FIFO full flag.
- `data_out` out 8: last good byte; connects to FIFO `data_in`.
- `data_valid` out 1: one-cycle pulse; connects to FIFO `push`.
- `frame_err` out 1: one-cycle pulse when the stop bit is sampled low.
- `overrun` out 1: one-cycle pulse when a good byte is dropped because `fifo_full`=1.
- `busy` out 1: high in every state except IDLE.

## Operation
- Synchronizer: `rx_bit` passes through `SYNC_STAGES` flops, and all logic uses the synchronized value `rxs`. Synchronizer flops reset to 1.
- Tick divider: 8-bit counter.
  - When the counter is ≥ `freq_div`: `tick`=1 for that cycle and the counter clears.
  - Otherwise the counter increments.
  - The ≥ comparison means a mid-frame decrease of `freq_div` takes effect without a 256-count wrap.
  - `freq_div`=0 gives a tick every cycle.
- Sample counter: 4-bit, advances only on `tick`, wraps 15→0. Bit counter: 3-bit.
- Voting: samples are taken on sample counts 7, 8 and 9. The bit value is the majority of the three, decided on count 9.
- FSM (all transitions occur only on `tick`):
  - IDLE: if `rxs`=0 → START; this tick is count 0.
  - START: at count 9, if vote=1 (glitch) → IDLE with no output. At count 15 → DATA, bit counter 0.
  - DATA: at count 9, shift the vote into bit[bitcnt] (LSB first). At count 15, if bitcnt=7 → STOP, else bitcnt+1.
  - STOP: at count 9:
    - vote=1 and `fifo_full`=0: `data_out` ← shift register, `data_valid` pulse → IDLE.
    - vote=1 and `fifo_full`=1: `overrun` pulse, `data_out` unchanged → IDLE.
    - vote=0: `frame_err` pulse, `data_out` unchanged → BREAK.
  - BREAK: stays until a tick with `rxs`=1 → IDLE. A held-low line therefore produces exactly one `frame_err`.
- Returning to IDLE at stop count 9, rather than 15, allows resynchronisation to back-to-back frames.
- `fifo_full` is sampled only on the STOP decision tick.

## Timing
- Reset values:
  - `data_out`=0x00; `data_valid`, `frame_err`, `overrun`, `busy` = 0.
  - FSM in IDLE; divider, sample and bit counters at 0; shift register 0x00.
- All outputs are registered.
- Latency, with `SYNC_STAGES`=2 and `freq_div`=0: let E0 be the first clk edge whose synchronizer stage 1 captures the falling start edge.
  - FSM leaves IDLE at edge E0+2.
  - `data_valid` is high for exactly the one cycle after edge E0+155 (16+128+9 ticks after the start detection).
  - General case: stop decision occurs 153 ticks after the detection tick.
- At most one of `data_valid`/`overrun`/`frame_err` pulses per frame, each for exactly 1 clk.
- `busy` goes high the cycle after START entry and low the cycle after returning to IDLE.
- Reset asserted mid-frame: the next edge returns every register to its reset value. The partial byte is discarded and no pulse is emitted.
- `freq_div` changes mid-frame: no protection is given; framing of the current byte is undefined, and subsequent frames are correct.

## Test plan
- `freq_div`=0, send 0x55 at 16 clk/bit → `data_out`=0x55, a single `data_valid` after edge E0+155, `busy` low afterwards.
- `freq_div`=5, send 0xA3 then 0x0F back-to-back (no idle gap) → two `data_valid` pulses with 0xA3 then 0x0F; no errors.
- `freq_div`=0, 4-clk low glitch on an idle line → no pulse; `busy` returns to 0 within 11 cycles of detection.
- `freq_div`=0, frame 0x81 with stop bit low, then line held low for 500 clk, then high, then send 0x42 → one `frame_err` and no `data_valid` for the bad frame; `data_out` stays at its previous value; then `data_valid` with 0x42.
- `fifo_full`=1 during the stop bit of 0x3C → `overrun` pulse, no `data_valid`, `data_out` unchanged. After dropping `fifo_full`, send 0x3C → `data_valid` with 0x3C.
- Reset pulsed during data bit 4 of a frame → no output pulse; the next complete frame (0xE7) is received correctly.

Source files
------------

// File: rtl/uart_rx_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_if -- receiver-to-RX-FIFO byte handoff and status
// Revision : 1.0
// ============================================================================
interface uart_rx_if;
  logic       fifo_full;
  logic [7:0] data_out;
  logic       data_valid;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  modport master (
    input  fifo_full,
    output data_out, data_valid, frame_err, overrun, busy
  );

  modport slave (
    output fifo_full,
    input  data_out, data_valid, frame_err, overrun, busy
  );
endinterface
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx -- 16x oversampled 8N1 receiver feeding the RX FIFO
// Revision : 1.0
// ============================================================================
module uart_rx #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_bit,
  input  logic [7:0] freq_div,
  uart_rx_if.master  rx_if
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } state_t;

  localparam logic [3:0] c_SAMPLE_A = 4'd7;
  localparam logic [3:0] c_SAMPLE_B = 4'd8;
  localparam logic [3:0] c_DECIDE   = 4'd9;
  localparam logic [3:0] c_LAST     = 4'd15;

  logic [SYNC_STAGES-1:0] r_sync;
  logic [7:0]             r_div_cnt;
  logic [3:0]             r_sample_cnt;
  logic [2:0]             r_bit_cnt;
  logic [7:0]             r_shift;
  logic                   r_s7;
  logic                   r_s8;
  state_t                 r_state;

  logic [7:0] r_data_out;
  logic       r_data_valid;
  logic       r_frame_err;
  logic       r_overrun;
  logic       r_busy;

  logic       w_rxs;
  logic       w_tick;
  logic       w_vote;
  logic       w_mid;
  logic       w_last;
  state_t     w_state_next;
  logic [3:0] w_sample_next;
  logic [2:0] w_bit_next;
  logic [7:0] w_shift_next;
  logic [7:0] w_data_next;
  logic       w_valid_next;
  logic       w_ferr_next;
  logic       w_ovr_next;

  assign w_rxs  = r_sync[SYNC_STAGES-1];
  // >= rather than == so a lowered freq_div never forces a 256-count wrap
  assign w_tick = (r_div_cnt >= freq_div);
  assign w_mid  = (r_sample_cnt == c_DECIDE);
  assign w_last = (r_sample_cnt == c_LAST);
  assign w_vote = (r_s7 & r_s8) | (r_s7 & w_rxs) | (r_s8 & w_rxs);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync    <= '1;
      r_div_cnt <= 8'd0;
      r_s7      <= 1'b0;
      r_s8      <= 1'b0;
    end else begin
      r_sync    <= {r_sync[SYNC_STAGES-2:0], rx_bit};
      r_div_cnt <= w_tick ? 8'd0 : r_div_cnt + 8'd1;
      if (w_tick && r_sample_cnt == c_SAMPLE_A) r_s7 <= w_rxs;
      if (w_tick && r_sample_cnt == c_SAMPLE_B) r_s8 <= w_rxs;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_sample_cnt <= 4'd0;
      r_bit_cnt    <= 3'd0;
      r_shift      <= 8'h00;
      r_data_out   <= 8'h00;
      r_data_valid <= 1'b0;
      r_frame_err  <= 1'b0;
      r_overrun    <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_sample_cnt <= w_sample_next;
      r_bit_cnt    <= w_bit_next;
      r_shift      <= w_shift_next;
      r_data_out   <= w_data_next;
      r_data_valid <= w_valid_next;
      r_frame_err  <= w_ferr_next;
      r_overrun    <= w_ovr_next;
      r_busy       <= (w_state_next != S_IDLE);
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_sample_next = r_sample_cnt;
    w_bit_next    = r_bit_cnt;
    w_shift_next  = r_shift;
    w_data_next   = r_data_out;
    w_valid_next  = 1'b0;
    w_ferr_next   = 1'b0;
    w_ovr_next    = 1'b0;
    if (w_tick) begin
      w_sample_next = r_sample_cnt + 4'd1;
      case (r_state)
        S_IDLE: begin
          w_sample_next = 4'd0;
          // The detection tick is sample 0, so the next tick is sample 1
          if (!w_rxs) begin
            w_state_next  = S_START;
            w_sample_next = 4'd1;
          end
        end
        S_START: begin
          if (w_mid && w_vote) begin
            w_state_next  = S_IDLE;
            w_sample_next = 4'd0;
          end else if (w_last) begin
            w_state_next = S_DATA;
            w_bit_next   = 3'd0;
          end
        end
        S_DATA: begin
          if (w_mid) w_shift_next[r_bit_cnt] = w_vote;
          if (w_last) begin
            if (r_bit_cnt == 3'd7) w_state_next = S_STOP;
            else                   w_bit_next   = r_bit_cnt + 3'd1;
          end
        end
        S_STOP: begin
          // Deciding at mid-stop leaves half a bit to catch a back-to-back start edge
          if (w_mid) begin
            w_sample_next = 4'd0;
            if (!w_vote) begin
              w_state_next = S_BREAK;
              w_ferr_next  = 1'b1;
            end else begin
              w_state_next = S_IDLE;
              if (rx_if.fifo_full) begin
                w_ovr_next = 1'b1;
              end else begin
                w_valid_next = 1'b1;
                w_data_next  = r_shift;
              end
            end
          end
        end
        S_BREAK: begin
          w_sample_next = 4'd0;
          if (w_rxs) w_state_next = S_IDLE;
        end
        default: begin
          w_state_next  = S_IDLE;
          w_sample_next = 4'd0;
        end
      endcase
    end
  end

  assign rx_if.data_out   = r_data_out;
  assign rx_if.data_valid = r_data_valid;
  assign rx_if.frame_err  = r_frame_err;
  assign rx_if.overrun    = r_overrun;
  assign rx_if.busy       = r_busy;

endmodule
`default_nettype wire
